spi_sclk_engine: RTL and testbench

Parametrised SPI master serial-clock engine: next generation of the SPI baud-rate generator. It computes the divisor from the prescaler and exponent fields, and runs a start/busy/done frame sequencer over a programmable number of bits. It also produces CPOL/CPHA-aware sample and shift strobes, each with a one-cycle early variant. It sits between the SPI control registers and the shift-register/SS logic of the SPI master.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_div_counter.sv | 50 +++++
 rtl/spi_sclk_engine.sv | 143 ++++++++++++++
 tb/tb_spi_sclk_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI serial-clock engine and its register block.
package spi_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Divisor width: (2^PRE_W) << 2^EXP_W needs PRE_W + 2^EXP_W + 1 bits
    function automatic int unsigned div_w(input int unsigned pre_w, input int unsigned exp_w);
        return pre_w + (32'd1 << exp_w) + 32'd1;
    endfunction

endpackage : spi_pkg

// File: rtl/spi_div_counter.sv
// Half-period counter: counts PClk cycles up to the divisor and flags the
// wrap cycle (edge_pulse) and the cycle before it (pre_edge_pulse).
// Freeze is taken through a register so that the hold and the strobe
// gating line up in the same cycle without any input-to-output path.
module spi_div_counter
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             freeze,
    input  logic [DIV_W-1:0] div,
    output logic             edge_pulse,
    output logic             pre_edge_pulse
);

    logic [DIV_W-1:0] hcnt;
    logic [DIV_W-1:0] wrap_val;
    logic [DIV_W-1:0] pre_val;
    logic             freeze_q;
    logic             active;

    // Compare points and the counting qualifier; div is never below 2
    always_comb begin
        wrap_val       = div - DIV_W'(1);
        pre_val        = div - DIV_W'(2);
        active         = enable & ~freeze_q;
        edge_pulse     = active & (hcnt == wrap_val);
        pre_edge_pulse = active & (hcnt == pre_val);
    end

    // Counter and registered freeze; a frozen cycle neither counts nor wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze;
            if (clear) begin
                hcnt <= '0;
            end else if (active) begin
                hcnt <= (hcnt == wrap_val) ? '0 : hcnt + DIV_W'(1);
            end
        end
    end

endmodule : spi_div_counter

// File: rtl/spi_sclk_engine.sv
// SPI master serial-clock engine: latches the frame configuration on start,
// runs the RUN/GUARD/DONE sequence and steers the counter's edge pulses
// into CPOL/CPHA-aware sample and shift strobes.
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter  int unsigned PRE_W = 3,
    parameter  int unsigned EXP_W = 3,
    parameter  int unsigned LEN_W = 5,
    localparam int unsigned DIV_W = div_w(PRE_W, EXP_W)
) (
    input  logic             PClk,
    input  logic             PRESET,
    input  logic             start,
    input  logic             freeze,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [PRE_W-1:0] sppr,
    input  logic [EXP_W-1:0] spr,
    input  logic [LEN_W-1:0] frame_len,
    output logic             sclk,
    output logic             busy,
    output logic             done,
    output logic             load_strb,
    output logic             sample_strb,
    output logic             shift_strb,
    output logic             pre_sample_strb,
    output logic             pre_shift_strb,
    output logic [DIV_W-1:0] divisor
);

    // Edge counter holds 0 .. 2N-1, N up to 2^LEN_W
    localparam int unsigned ECNT_W = LEN_W + 1;

    state_t            state;
    logic              cpol_q;
    logic              cpha_q;
    logic [LEN_W-1:0]  len_q;
    logic [ECNT_W-1:0] ecnt;
    logic [DIV_W-1:0]  div_new;
    logic              accept;
    logic              cnt_enable;
    logic              edge_pulse;
    logic              pre_edge_pulse;
    logic              leading;
    logic              last_edge;
    logic              run_edge;
    logic              run_pre;

    // Divisor of the incoming config and counter control
    always_comb begin
        div_new    = (DIV_W'(sppr) + DIV_W'(1)) << (DIV_W'(spr) + DIV_W'(1));
        accept     = (state == ST_IDLE) & start;
        cnt_enable = (state == ST_RUN) | (state == ST_GUARD);
    end

    spi_div_counter #(
        .DIV_W (DIV_W)
    ) u_div_counter (
        .clk            (PClk),
        .rst            (PRESET),
        .clear          (accept),
        .enable         (cnt_enable),
        .freeze         (freeze),
        .div            (divisor),
        .edge_pulse     (edge_pulse),
        .pre_edge_pulse (pre_edge_pulse)
    );

    // Strobe steering: ecnt even means the pending edge is a leading one;
    // the CPHA=0 final trailing edge carries no shift
    always_comb begin
        leading         = ~ecnt[0];
        last_edge       = (ecnt == {len_q, 1'b1});
        run_edge        = (state == ST_RUN) & edge_pulse;
        run_pre         = (state == ST_RUN) & pre_edge_pulse;
        sample_strb     = run_edge & (cpha_q ? ~leading : leading);
        shift_strb      = run_edge & (cpha_q ? leading : (~leading & ~last_edge));
        pre_sample_strb = run_pre  & (cpha_q ? ~leading : leading);
        pre_shift_strb  = run_pre  & (cpha_q ? leading : (~leading & ~last_edge));
    end

    // Frame sequencer with registered config, sclk, busy, done and load strobe
    always_ff @(posedge PClk) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            sclk      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_strb <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            len_q     <= '0;
            divisor   <= DIV_W'(2);
            ecnt      <= '0;
        end else begin
            done      <= 1'b0;
            load_strb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk <= cpol_q;
                    if (start) begin
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        len_q     <= frame_len;
                        divisor   <= div_new;
                        sclk      <= cpol;
                        ecnt      <= '0;
                        busy      <= 1'b1;
                        load_strb <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (edge_pulse) begin
                        if (last_edge) begin
                            sclk  <= cpol_q;
                            ecnt  <= '0;
                            state <= ST_GUARD;
                        end else begin
                            sclk <= ~sclk;
                            ecnt <= ecnt + ECNT_W'(1);
                        end
                    end
                end
                ST_GUARD: begin
                    if (edge_pulse) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : spi_sclk_engine

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: directed frames plus randomized
// frames compared cycle by cycle against a tick-count reference model.
module tb_spi_sclk_engine;

    logic        PClk = 1'b0;
    logic        PRESET;
    logic        start;
    logic        freeze;
    logic        cpol;
    logic        cpha;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic [4:0]  frame_len;
    logic        sclk;
    logic        busy;
    logic        done;
    logic        load_strb;
    logic        sample_strb;
    logic        shift_strb;
    logic        pre_sample_strb;
    logic        pre_shift_strb;
    logic [11:0] divisor;

    int n_checks = 0;
    int n_bad    = 0;

    spi_sclk_engine #(
        .PRE_W (3),
        .EXP_W (3),
        .LEN_W (5)
    ) dut (
        .PClk            (PClk),
        .PRESET          (PRESET),
        .start           (start),
        .freeze          (freeze),
        .cpol            (cpol),
        .cpha            (cpha),
        .sppr            (sppr),
        .spr             (spr),
        .frame_len       (frame_len),
        .sclk            (sclk),
        .busy            (busy),
        .done            (done),
        .load_strb       (load_strb),
        .sample_strb     (sample_strb),
        .shift_strb      (shift_strb),
        .pre_sample_strb (pre_sample_strb),
        .pre_shift_strb  (pre_shift_strb),
        .divisor         (divisor)
    );

    always #5 PClk = ~PClk;

    // Run-away guard
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {pad, divisor, sclk, busy, done, load, sample, shift, pre_sample, pre_shift}
    function automatic logic [31:0] obs_vec();
        return {12'h0, divisor, sclk, busy, done, load_strb,
                sample_strb, shift_strb, pre_sample_strb, pre_shift_strb};
    endfunction

    task automatic tick();
        @(posedge PClk);
        #1;
    endtask

    // One frame from the acceptance edge to the first IDLE cycle after done.
    // Model: every non-frozen cycle of the frame is one tick; tick t ends
    // edge (t+1)/DIV when (t+1) is a multiple of DIV; 2N edges then DIV
    // guard ticks, then one DONE cycle.
    task automatic run_frame(input int pre, input int ex, input int len,
                             input bit pol, input bit pha,
                             input int fs, input int fl, input bit noise,
                             input string name);
        int dv, n2, total, p, c_dm, done_at, first_tog, n_samp, n_shift;
        int t, k, kp, ed;
        bit frz, e_edge, e_pre, e_sclk, e_busy, e_done, e_load;
        bit e_samp, e_shft, e_psamp, e_pshft;
        logic [31:0] expv;

        dv    = (pre + 1) << (ex + 1);
        n2    = 2 * (len + 1);
        total = (n2 + 1) * dv;

        sppr      = 3'(pre);
        spr       = 3'(ex);
        frame_len = 5'(len);
        cpol      = pol;
        cpha      = pha;
        freeze    = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;

        p = 0; frz = 1'b0; c_dm = -1; done_at = 0; first_tog = 0;
        n_samp = 0; n_shift = 0;
        for (int c = 1; c <= total + fl + 20; c++) begin
            e_samp = 1'b0; e_shft = 1'b0; e_psamp = 1'b0; e_pshft = 1'b0;
            if (p < total) begin
                e_busy = 1'b1;
                e_done = 1'b0;
                t  = p;
                ed = t / dv;
                e_sclk = pol ^ (ed % 2 == 1);
                k  = (t + 1) / dv;
                kp = (t + 2) / dv;
                e_edge = !frz && ((t + 1) % dv == 0) && (k <= n2);
                e_pre  = !frz && ((t + 2) % dv == 0) && (kp <= n2);
                e_samp  = e_edge && (pha ? (k % 2 == 0) : (k % 2 == 1));
                e_shft  = e_edge && (pha ? (k % 2 == 1) : ((k % 2 == 0) && (k != n2)));
                e_psamp = e_pre && (pha ? (kp % 2 == 0) : (kp % 2 == 1));
                e_pshft = e_pre && (pha ? (kp % 2 == 1) : ((kp % 2 == 0) && (kp != n2)));
            end else begin
                e_busy = (c == c_dm);
                e_done = (c == c_dm);
                e_sclk = pol;
            end
            e_load = (c == 1);
            expv = {12'h0, 12'(dv), e_sclk, e_busy, e_done, e_load,
                    e_samp, e_shft, e_psamp, e_pshft};
            check($sformatf("%s c%0d", name, c), obs_vec(), expv);

            if (done === 1'b1 && done_at == 0) done_at = c;
            if (sclk !== pol && first_tog == 0) first_tog = c;
            n_samp  += int'(sample_strb);
            n_shift += int'(shift_strb);

            if (c_dm > 0 && c == c_dm + 1) break;

            // Inputs for the next edge
            freeze = (c >= fs) && (c < fs + fl);
            start  = noise ? 1'($urandom % 2) : 1'b0;
            if (noise) begin
                cpol      = 1'($urandom);
                cpha      = 1'($urandom);
                sppr      = 3'($urandom);
                spr       = 3'($urandom);
                frame_len = 5'($urandom);
            end

            if (p < total && !frz) begin
                p++;
                if (p == total) c_dm = c + 1;
            end
            frz = freeze;
            tick();
        end
        start  = 1'b0;
        freeze = 1'b0;

        check({name, " done_at"}, 32'(done_at), 32'((n2 + 1) * dv + 1 + fl));
        check({name, " n_sample"}, 32'(n_samp), 32'(n2 / 2));
        check({name, " n_shift"}, 32'(n_shift), 32'(pha ? n2 / 2 : n2 / 2 - 1));
        if (fs > dv + 1) check({name, " first_toggle"}, 32'(first_tog), 32'(dv + 1));
    endtask

    initial begin
        int pre, ex, len, dv, fs, fl;
        bit pol, pha, noise;

        PRESET = 1'b1; start = 1'b0; freeze = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sppr = '0; spr = '0; frame_len = '0;
        repeat (3) tick();
        check("reset", obs_vec(), {12'h0, 12'd2, 8'h00});
        PRESET = 1'b0;
        tick();
        check("reset_idle", obs_vec(), {12'h0, 12'd2, 8'h00});

        // Basic mode 0, divisor 2, 8 bits; then back-to-back mode 3 frame
        run_frame(0, 0, 7, 1'b0, 1'b0, 1000, 0, 1'b0, "t1_mode0");
        run_frame(2, 1, 0, 1'b1, 1'b1, 1000, 0, 1'b0, "t2_mode3");
        tick();
        // Largest divisor, full-width compare
        run_frame(7, 7, 0, 1'b0, 1'b0, 10000, 0, 1'b0, "t3_div2048");
        // Ten frozen cycles mid-RUN
        run_frame(1, 1, 3, 1'b0, 1'b1, 9, 10, 1'b0, "t4_freeze");
        // Start pulses and config churn while busy
        run_frame(3, 0, 2, 1'b1, 1'b0, 1000, 0, 1'b1, "t5_noise");

        // Reset at edge 5 of a frame with divisor 4
        sppr = 3'd1; spr = 3'd0; frame_len = 5'd7; cpol = 1'b1; cpha = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("preset_mid", obs_vec(), {12'h0, 12'd2, 8'h00});
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("preset_idle%0d", i), obs_vec(), {12'h0, 12'd2, 8'h00});
        end
        run_frame(1, 0, 3, 1'b0, 1'b1, 1000, 0, 1'b0, "t6_after_reset");

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            pre   = int'($urandom_range(0, 7));
            ex    = int'($urandom_range(0, 2));
            len   = int'($urandom_range(0, 7));
            pol   = 1'($urandom);
            pha   = 1'($urandom);
            noise = 1'($urandom);
            dv    = (pre + 1) << (ex + 1);
            fs    = int'($urandom_range(1, 32'(dv * (len + 1))));
            fl    = int'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) tick();
            run_frame(pre, ex, len, pol, pha, fs, fl, noise, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_spi_sclk_engine
